ring_buf_ctrl: RTL and testbench
================================

RING_BUF_CTRL -- requirements
Module: ring_buf_ctrl

Interface
REQ-001 Parameter pBITS, default 8, data word width.
REQ-002 Parameter pWIDHT, default 2, address width; depth DEPTH = 2**pWIDHT.
REQ-003 Parameter pAFULL, default 3, almost-full threshold in words (1..DEPTH).
REQ-004 iclk  input  1  single clock; all logic on rising edge.
REQ-005 irst  input  1  reset, synchronous, active-high.
REQ-006 iflush  input  1  synchronous flush, empties buffer.
REQ-007 iwr_valid  input  1  write request.
REQ-008 owr_ready  output  1  write accepted when high with iwr_valid.
REQ-009 iw_data  input  pBITS  write data.
REQ-010 ord_valid  output  1  or_data holds the oldest unread word.
REQ-011 ird_ready  input  1  consumer pops when high with ord_valid.
REQ-012 or_data  output  pBITS  head-of-buffer data (first-word fall-through).
REQ-013 ocount  output  pWIDHT+1  words stored, 0..DEPTH.
REQ-014 ofull, oempty, oalmost_full  output  1 each  status flags.
REQ-015 ooverflow  output  1  sticky: a write was attempted while not ready.

Function
REQ-016 Push = iwr_valid && owr_ready; pop = ord_valid && ird_ready; both evaluated in the same cycle.
REQ-017 Write and read pointers are pWIDHT+1 bits; the low pWIDHT bits address storage; the MSB is the wrap bit; each pointer increments by 1 per push/pop and wraps modulo 2*DEPTH.
REQ-018 oempty = (wr_ptr == rd_ptr); ofull = low bits equal and MSBs differ; both are combinational from the registered pointers.
REQ-019 ocount = wr_ptr - rd_ptr, modulo 2**(pWIDHT+1); oalmost_full = (ocount >= pAFULL).
REQ-020 owr_ready = !ofull && !irst; ord_valid = !oempty && !irst.
REQ-021 A push writes iw_data to storage at wr_ptr[pWIDHT-1:0] on the same edge that advances wr_ptr.
REQ-022 or_data = storage[rd_ptr[pWIDHT-1:0]] combinationally; a word pushed at edge N is visible with ord_valid=1 after edge N (latency 1).
REQ-023 Simultaneous push and pop when neither full nor empty: both pointers advance; ocount is unchanged.
REQ-024 When full, owr_ready=0 even if a pop occurs in the same cycle; there is no write-through when full.
REQ-025 When empty, a push is accepted, but ord_valid stays 0 until the next cycle; there is no bypass.
REQ-026 ooverflow sets on any cycle with iwr_valid && !owr_ready && !irst, and holds until reset or flush.
REQ-027 iflush=1: on the next edge both pointers become 0 and ooverflow becomes 0; a push or pop in the same cycle is discarded.
REQ-028 Storage contents are never cleared; only the pointers define validity.

Reset
REQ-029 Priority is irst > iflush > push/pop.
REQ-030 After irst: wr_ptr=rd_ptr=0, ooverflow=0, oempty=1, ofull=0, oalmost_full=0, ocount=0; ord_valid=0 and owr_ready=0 while irst=1, and owr_ready=1 on the first cycle after release.
REQ-031 Reset mid-operation discards all stored words; no push or pop completes in a cycle with irst=1.

Structure
REQ-032 The shared package holds the pointer width function (pWIDHT+1) and the full/empty compare helper; there are no typedefs beyond these.
REQ-033 Storage is one instance of the existing reg_file (pBITS, pWIDHT), driven with iwr_en=push, iw_addr=wr_ptr low bits, ir_addr=rd_ptr low bits; its irst pin is tied to irst.
REQ-034 The controller contains only the pointers, flags and ooverflow register; it contains no second storage array.

Verification (pBITS=8, pWIDHT=2, pAFULL=3)
REQ-035 Push 0x11,0x22,0x33,0x44 with ird_ready=0 -> ocount 1,2,3,4; oalmost_full at count 3; ofull=1 and owr_ready=0 at count 4.
REQ-036 From full, hold iwr_valid=1 with 0x55 and pop 4 words -> or_data 0x11,0x22,0x33,0x44 in order; ooverflow=1; 0x55 never appears until owr_ready rises.
REQ-037 Continuous push and pop for 10 words (0x00..0x09) after one prefill -> ocount stays 1; output order matches input across two pointer wraps.
REQ-038 Empty buffer, push 0xA5 -> ord_valid=0 in the push cycle, and ord_valid=1 with or_data=0xA5 on the next cycle.
REQ-039 Two words stored, ooverflow=1, assert iflush with iwr_valid=1 -> next cycle oempty=1, ocount=0, ooverflow=0, and the pushed word is discarded.
REQ-040 Assert irst for 1 cycle with 3 words stored -> during irst owr_ready=0 and ord_valid=0; after release oempty=1, ocount=0, owr_ready=1.

Source files
------------

// File: rtl/ring_buf_ctrl_pkg.sv
// Shared helpers for the ring buffer controller: pointer width and full compare.
package ring_buf_ctrl_pkg;

    // Pointers carry one extra wrap bit above the storage address.
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

    // Full when the storage addresses match but the wrap bits differ.
    function automatic logic ptr_full(input logic lo_eq, input logic wr_msb, input logic rd_msb);
        return lo_eq && (wr_msb != rd_msb);
    endfunction

endpackage

// File: rtl/reg_file.sv
// Simple register file: one synchronous write port, one combinational read port.
// Contents are never cleared; reset only suppresses writes.
module reg_file #(
    parameter int pBITS  = 8,
    parameter int pWIDHT = 2
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              iwr_en,
    input  logic [pWIDHT-1:0] iw_addr,
    input  logic [pBITS-1:0]  iw_data,
    input  logic [pWIDHT-1:0] ir_addr,
    output logic [pBITS-1:0]  or_data
);

    logic [pBITS-1:0] r_mem [2**pWIDHT];

    // Write the addressed word; a write in a reset cycle is dropped.
    always_ff @(posedge iclk) begin
        if (iwr_en && !irst) begin
            r_mem[iw_addr] <= iw_data;
        end
    end

    assign or_data = r_mem[ir_addr];

endmodule

// File: rtl/ring_buf_ctrl.sv
// Ring buffer controller: first-word fall-through FIFO built from pointers
// around an external reg_file. Flags are derived combinationally from the
// registered pointers; ooverflow is sticky until reset or flush.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready/valid never depend combinationally on the partner's
// valid/ready, and both are held low during reset.
module ring_buf_ctrl
    import ring_buf_ctrl_pkg::*;
#(
    parameter int pBITS  = 8,
    parameter int pWIDHT = 2,
    parameter int pAFULL = 3
) (
    input  logic              iclk,
    input  logic              irst,
    input  logic              iflush,
    input  logic              iwr_valid,
    output logic              owr_ready,
    input  logic [pBITS-1:0]  iw_data,
    output logic              ord_valid,
    input  logic              ird_ready,
    output logic [pBITS-1:0]  or_data,
    output logic [pWIDHT:0]   ocount,
    output logic              ofull,
    output logic              oempty,
    output logic              oalmost_full,
    output logic              ooverflow
);

    localparam int PW = ptr_width(pWIDHT);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic [PW-1:0] w_count;
    logic          w_push;
    logic          w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = ptr_full(r_wr_ptr[pWIDHT-1:0] == r_rd_ptr[pWIDHT-1:0],
                              r_wr_ptr[PW-1], r_rd_ptr[PW-1]);
    assign w_count = r_wr_ptr - r_rd_ptr;

    assign owr_ready    = !w_full && !irst;
    assign ord_valid    = !w_empty && !irst;
    assign w_push       = iwr_valid && owr_ready;
    assign w_pop        = ord_valid && ird_ready;

    assign ocount       = w_count;
    assign ofull        = w_full;
    assign oempty       = w_empty;
    assign oalmost_full = (w_count >= PW'(pAFULL));
    assign ooverflow    = r_overflow;

    // Pointer and sticky-overflow update; reset beats flush beats push/pop.
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (iflush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (iwr_valid && !owr_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    reg_file #(
        .pBITS  (pBITS),
        .pWIDHT (pWIDHT)
    ) u_reg_file (
        .iclk    (iclk),
        .irst    (irst),
        .iwr_en  (w_push),
        .iw_addr (r_wr_ptr[pWIDHT-1:0]),
        .iw_data (iw_data),
        .ir_addr (r_rd_ptr[pWIDHT-1:0]),
        .or_data (or_data)
    );

endmodule

// File: tb/tb_ring_buf_ctrl.sv
// Bench for ring_buf_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based FIFO model.
module tb_ring_buf_ctrl;

    localparam int W     = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;

    logic          iclk;
    logic          irst;
    logic          iflush;
    logic          iwr_valid;
    logic          owr_ready;
    logic [W-1:0]  iw_data;
    logic          ord_valid;
    logic          ird_ready;
    logic [W-1:0]  or_data;
    logic [AW:0]   ocount;
    logic          ofull;
    logic          oempty;
    logic          oalmost_full;
    logic          ooverflow;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [W-1:0] exp_q[$];
    logic         exp_ovf;

    ring_buf_ctrl #(
        .pBITS  (W),
        .pWIDHT (AW),
        .pAFULL (AFULL)
    ) dut (
        .iclk         (iclk),
        .irst         (irst),
        .iflush       (iflush),
        .iwr_valid    (iwr_valid),
        .owr_ready    (owr_ready),
        .iw_data      (iw_data),
        .ord_valid    (ord_valid),
        .ird_ready    (ird_ready),
        .or_data      (or_data),
        .ocount       (ocount),
        .ofull        (ofull),
        .oempty       (oempty),
        .oalmost_full (oalmost_full),
        .ooverflow    (ooverflow)
    );

    // Clock
    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the model says for the current inputs.
    task automatic check_all(input string tag);
        int n;
        n = exp_q.size();
        chk({tag, "_count"}, 32'(ocount), 32'(n));
        chk({tag, "_empty"}, 32'(oempty), 32'(n == 0));
        chk({tag, "_full"}, 32'(ofull), 32'(n == DEPTH));
        chk({tag, "_afull"}, 32'(oalmost_full), 32'(n >= AFULL));
        chk({tag, "_ovf"}, 32'(ooverflow), 32'(exp_ovf));
        chk({tag, "_wready"}, 32'(owr_ready), 32'((n != DEPTH) && !irst));
        chk({tag, "_rvalid"}, 32'(ord_valid), 32'((n != 0) && !irst));
        if (n != 0) begin
            chk({tag, "_data"}, 32'(or_data), 32'(exp_q[0]));
        end
    endtask

    // Apply inputs just after an edge, then check outputs before the next edge.
    task automatic drive(input string tag, input logic wv, input logic [W-1:0] d,
                         input logic rr, input logic fl, input logic rs);
        iwr_valid = wv;
        iw_data   = d;
        ird_ready = rr;
        iflush    = fl;
        irst      = rs;
        #1;
        check_all(tag);
    endtask

    // Advance one clock and apply the FIFO rules to the model.
    task automatic tick();
        logic was_full;
        logic was_empty;
        @(posedge iclk);
        was_full  = (exp_q.size() == DEPTH);
        was_empty = (exp_q.size() == 0);
        if (irst || iflush) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (iwr_valid && was_full) exp_ovf = 1'b1;
            if (ird_ready && !was_empty) void'(exp_q.pop_front());
            if (iwr_valid && !was_full) exp_q.push_back(iw_data);
        end
        #1;
    endtask

    initial begin
        logic [W-1:0] d8;
        irst      = 1'b1;
        iflush    = 1'b0;
        iwr_valid = 1'b0;
        iw_data   = '0;
        ird_ready = 1'b0;
        exp_ovf   = 1'b0;
        repeat (2) @(posedge iclk);
        #1;

        // Still in reset: handshakes held low, pointers cleared.
        drive("rst_hold", 1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        tick();

        // First cycle out of reset.
        drive("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset_wready_now", 32'(owr_ready), 32'd1);
        tick();

        // Fill to full with the consumer stalled.
        for (int i = 1; i <= 4; i++) begin
            d8 = 8'(i * 8'h11);
            drive("fill", 1'b1, d8, 1'b0, 1'b0, 1'b0);
            tick();
            chk("fill_count", 32'(ocount), 32'(i));
        end
        chk("fill_afull", 32'(oalmost_full), 32'd1);
        chk("fill_full", 32'(ofull), 32'd1);
        chk("fill_wready", 32'(owr_ready), 32'd0);

        // Hold a write of 0x55 while draining from full.
        for (int i = 0; i < 4; i++) begin
            drive("drain55", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
            if (i == 0) chk("drain55_first", 32'(or_data), 32'h11);
            tick();
        end
        chk("drain55_ovf", 32'(ooverflow), 32'd1);
        while (exp_q.size() != 0) begin
            drive("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            tick();
        end

        // Clear overflow, then push into an empty buffer: no bypass.
        drive("flush0", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        drive("bypass", 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        chk("bypass_rvalid0", 32'(ord_valid), 32'd0);
        tick();
        drive("bypass_next", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("bypass_data", 32'(or_data), 32'hA5);
        tick();

        // Streaming: prefill one, then push and pop together across wraps.
        drive("prefill", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 9; i++) begin
            drive("stream", 1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_data", 32'(or_data), 32'(i - 1));
            tick();
            chk("stream_count", 32'(ocount), 32'd1);
        end
        drive("stream_last", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("stream_last_data", 32'(or_data), 32'h09);
        tick();

        // Two words stored with overflow set, then flush with a write pending.
        for (int i = 0; i < 5; i++) begin
            drive("ovf_fill", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive("ovf_pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            tick();
        end
        chk("preflush_count", 32'(ocount), 32'd2);
        chk("preflush_ovf", 32'(ooverflow), 32'd1);
        drive("flush", 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        tick();
        drive("post_flush", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("post_flush_empty", 32'(oempty), 32'd1);
        chk("post_flush_ovf", 32'(ooverflow), 32'd0);
        tick();

        // Reset in mid-operation with three words stored.
        for (int i = 0; i < 3; i++) begin
            drive("pre_rst", 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive("mid_rst", 1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_wready", 32'(owr_ready), 32'd0);
        chk("mid_rst_rvalid", 32'(ord_valid), 32'd0);
        tick();
        drive("after_rst", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("after_rst_count", 32'(ocount), 32'd0);
        chk("after_rst_wready", 32'(owr_ready), 32'd1);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive("rand",
                  1'($urandom_range(0, 3) != 0),
                  8'($urandom),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 59) == 0));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
